// File: rtl/fetch_pkg.sv
// Shared opcode, condition-code and state encodings for the fetch controller.
package fetch_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StIssue   = 4'd2,
    StBrWait  = 4'd3,
    StJump    = 4'd4,
    StCall    = 4'd5,
    StRet     = 4'd6,
    StLmsk    = 4'd7,
    StIrqSave = 4'd8,
    StIrqVec  = 4'd9
  } state_e;

  localparam logic [4:0] OpBra  = 5'b00110;
  localparam logic [4:0] OpJmp  = 5'b00111;
  localparam logic [4:0] OpBsr  = 5'b10101;
  localparam logic [4:0] OpRts  = 5'b01000;
  localparam logic [4:0] OpRti  = 5'b01001;
  localparam logic [4:0] OpLmsk = 5'b01110;

  localparam logic [2:0] CcEq = 3'b000;
  localparam logic [2:0] CcNe = 3'b001;
  localparam logic [2:0] CcCs = 3'b010;
  localparam logic [2:0] CcCc = 3'b011;
  localparam logic [2:0] CcAl = 3'b111;

  function automatic logic cond_taken(input logic [2:0] cc, input logic z, input logic c);
    logic taken;
    unique case (cc)
      CcEq:    taken = z;
      CcNe:    taken = ~z;
      CcCs:    taken = c;
      CcCc:    taken = ~c;
      CcAl:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/fetch_rstack.sv
// Return-address LIFO: pushes onto a full stack and pops from an empty one are ignored.
module fetch_rstack #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned SpW = $clog2(Depth + 1);
  localparam int unsigned AW  = (Depth > 1) ? $clog2(Depth) : 1;

  logic [SpW-1:0]   sp_q, sp_d;
  logic [Width-1:0] mem_q [Depth];

  assign full_o  = (sp_q == SpW'(Depth));
  assign empty_o = (sp_q == '0);
  assign data_o  = empty_o ? '0 : mem_q[AW'(sp_q - SpW'(1))];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SpW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i && !full_o) begin
      mem_q[AW'(sp_q)] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch/sequencing FSM with return stack and optional interrupt entry.
// Interrupt entry, the mask register and in_isr exist only with FETCH_CTRL_IRQ_EN defined.
module fetch_ctrl #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     NIRQ     = 4,
  parameter int unsigned     BR_WAIT  = 2,
  parameter int unsigned     RS_DEPTH = 4,
  parameter logic [PC_W-1:0] VEC_BASE = 8'hF0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [7:0]      instr,
  input  logic [PC_W-1:0] operand,
  input  logic [NIRQ-1:0] irq,
  input  logic            ccr_z,
  input  logic            ccr_c,
  input  logic            stg1_ready,
  output logic            stg0_valid,
  output logic            fetch_en,
  output logic [PC_W-1:0] pc,
  output logic [NIRQ-1:0] itr_mask,
  output logic            in_isr,
  output logic            rs_err,
  output logic [3:0]      state
);

  import fetch_pkg::*;

  localparam int unsigned CntW = (BR_WAIT > 1) ? $clog2(BR_WAIT) : 1;

  state_e          state_q, state_d, bnd_state;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [PC_W-1:0] opnd_q, opnd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rs_err_q, rs_err_d;
  logic            br_last, irq_take;
  logic            rs_push, rs_pop, rs_full, rs_empty;
  logic [PC_W-1:0] rs_top;

  assign br_last = (cnt_q == CntW'(BR_WAIT - 1));

`ifdef FETCH_CTRL_IRQ_EN
  logic [NIRQ-1:0] mask_q, mask_d;
  logic            in_isr_q, in_isr_d;
  logic [PC_W-1:0] vec_q, vec_d, irq_idx;
  logic [NIRQ-1:0] pend;

  assign pend     = irq & mask_q;
  assign irq_take = (|pend) && !in_isr_q;

  // Lowest pending line wins.
  always_comb begin
    irq_idx = '0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (pend[i]) irq_idx = PC_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      mask_q   <= '0;
      in_isr_q <= 1'b0;
      vec_q    <= '0;
    end else begin
      mask_q   <= mask_d;
      in_isr_q <= in_isr_d;
      vec_q    <= vec_d;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = ^irq;
  assign irq_take   = 1'b0;
`endif

  assign bnd_state = irq_take ? StIrqSave : StFetch;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (instr[7:3])
          OpBra:        state_d = StIssue;
          OpJmp:        state_d = StJump;
          OpBsr:        state_d = StCall;
          OpRts, OpRti: state_d = StRet;
          OpLmsk:       state_d = StLmsk;
          default:      state_d = StIssue;
        endcase
      end
      StIssue: begin
        if (stg1_ready) state_d = (ir_q[7:3] == OpBra) ? StBrWait : bnd_state;
      end
      StBrWait: begin
        if (br_last) state_d = bnd_state;
      end
      StJump, StCall, StRet, StLmsk: state_d = bnd_state;
      StIrqSave: state_d = StIrqVec;
      StIrqVec:  state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    opnd_d   = opnd_q;
    cnt_d    = '0;
    rs_err_d = rs_err_q;
    rs_push  = 1'b0;
    rs_pop   = 1'b0;
`ifdef FETCH_CTRL_IRQ_EN
    mask_d   = mask_q;
    in_isr_d = in_isr_q;
    vec_d    = vec_q;
    // Vector is captured at the boundary so later irq changes cannot redirect it.
    if (state_d == StIrqSave && state_q != StIrqSave) vec_d = irq_idx;
`endif
    unique case (state_q)
      StFetch:  pc_d = pc_q + PC_W'(1);
      StDecode: begin
        ir_d   = instr;
        opnd_d = operand;
      end
      StBrWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (br_last && cond_taken(ir_q[2:0], ccr_z, ccr_c)) pc_d = opnd_q;
      end
      StJump: pc_d = opnd_q;
      StCall: begin
        rs_push = 1'b1;
        pc_d    = opnd_q;
        if (rs_full) rs_err_d = 1'b1;
      end
      StRet: begin
        rs_pop = 1'b1;
        if (rs_empty) rs_err_d = 1'b1;
        else          pc_d     = rs_top;
`ifdef FETCH_CTRL_IRQ_EN
        if (ir_q[7:3] == OpRti) in_isr_d = 1'b0;
`endif
      end
`ifdef FETCH_CTRL_IRQ_EN
      StLmsk: mask_d = opnd_q[NIRQ-1:0];
      StIrqSave: begin
        rs_push  = 1'b1;
        in_isr_d = 1'b1;
        if (rs_full) rs_err_d = 1'b1;
      end
      StIrqVec: pc_d = VEC_BASE + vec_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      pc_q     <= '0;
      ir_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      rs_err_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      rs_err_q <= rs_err_d;
    end
  end

  fetch_rstack #(
    .Depth (RS_DEPTH),
    .Width (PC_W)
  ) u_rstack (
    .clk_i   (clk),
    .rst_ni  (clr),
    .push_i  (rs_push),
    .pop_i   (rs_pop),
    .data_i  (pc_q),
    .data_o  (rs_top),
    .full_o  (rs_full),
    .empty_o (rs_empty)
  );

  // fetch_en is gated by clr so it stays low while reset is held in StFetch.
  always_comb begin
    fetch_en   = (state_q == StFetch) && clr;
    stg0_valid = (state_q == StIssue);
    pc         = pc_q;
    rs_err     = rs_err_q;
    state      = state_q;
`ifdef FETCH_CTRL_IRQ_EN
    itr_mask   = mask_q;
    in_isr     = in_isr_q;
`else
    itr_mask   = '0;
    in_isr     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; expectations follow FETCH_CTRL_IRQ_EN when defined.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] instr, operand;
  logic [3:0] irq;
  logic       ccr_z, ccr_c, stg1_ready;
  logic       stg0_valid, fetch_en, in_isr, rs_err;
  logic [7:0] pc;
  logic [3:0] itr_mask, state;
  logic       saw_irq = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl #(
    .PC_W     (8),
    .NIRQ     (4),
    .BR_WAIT  (2),
    .RS_DEPTH (4),
    .VEC_BASE (8'hF0)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .instr      (instr),
    .operand    (operand),
    .irq        (irq),
    .ccr_z      (ccr_z),
    .ccr_c      (ccr_c),
    .stg1_ready (stg1_ready),
    .stg0_valid (stg0_valid),
    .fetch_en   (fetch_en),
    .pc         (pc),
    .itr_mask   (itr_mask),
    .in_isr     (in_isr),
    .rs_err     (rs_err),
    .state      (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (state == 4'(StIrqSave) || state == 4'(StIrqVec)) saw_irq <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH back to FETCH with stage 1 always ready.
  task automatic exec(input logic [7:0] ins, input logic [7:0] opd);
    int n = 0;
    instr      = ins;
    operand    = opd;
    stg1_ready = 1'b1;
    step();
    while (state != 4'(StFetch) && n < 30) begin
      step();
      n++;
    end
    check_eq("exec_back_to_fetch", 32'(state), 32'(StFetch));
  endtask

  logic [7:0] bsr_tgt [5] = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
  logic [7:0] ret_exp [5] = '{8'hA1, 8'h91, 8'h81, 8'h41, 8'h42};

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b0; instr = 8'h00; operand = 8'h00; irq = 4'h0;
    ccr_z = 1'b0; ccr_c = 1'b0; stg1_ready = 1'b0;
    step();
    step();
    check_eq("rst_state", 32'(state), 32'(StFetch));
    check_eq("rst_pc", 32'(pc), 32'h0);
    check_eq("rst_fetch_en", 32'(fetch_en), 32'h0);
    check_eq("rst_valid", 32'(stg0_valid), 32'h0);
    check_eq("rst_rs_err", 32'(rs_err), 32'h0);
    check_eq("rst_mask", 32'(itr_mask), 32'h0);
    check_eq("rst_in_isr", 32'(in_isr), 32'h0);

    // NOP with stage 1 stalling
    clr = 1'b1;
    #1;
    check_eq("first_fetch", 32'(fetch_en), 32'h1);
    step();
    check_eq("nop_decode", 32'(state), 32'(StDecode));
    check_eq("nop_pc", 32'(pc), 32'h1);
    step();
    check_eq("nop_valid1", 32'(stg0_valid), 32'h1);
    step();
    check_eq("nop_valid2", 32'(stg0_valid), 32'h1);
    step();
    check_eq("nop_valid3", 32'(stg0_valid), 32'h1);
    stg1_ready = 1'b1;
    step();
    check_eq("nop_done_state", 32'(state), 32'(StFetch));
    check_eq("nop_done_valid", 32'(stg0_valid), 32'h0);
    check_eq("nop_done_fetch", 32'(fetch_en), 32'h1);
    check_eq("nop_done_pc", 32'(pc), 32'h1);

    // BEQ not taken, then taken with z rising only in the last wait cycle
    ccr_z = 1'b0;
    exec(8'h30, 8'h40);
    check_eq("beq_nt_pc", 32'(pc), 32'h2);
    instr = 8'h30; operand = 8'h40; ccr_z = 1'b0; stg1_ready = 1'b1;
    step();
    step();
    step();
    check_eq("beq_wait1", 32'(state), 32'(StBrWait));
    step();
    check_eq("beq_wait2", 32'(state), 32'(StBrWait));
    ccr_z = 1'b1;
    step();
    check_eq("beq_t_state", 32'(state), 32'(StFetch));
    check_eq("beq_t_pc", 32'(pc), 32'h40);
    ccr_z = 1'b0;

    // Return stack overflow and underflow
    for (int k = 0; k < 5; k++) begin
      exec(8'hA8, bsr_tgt[k]);
      check_eq("bsr_pc", 32'(pc), 32'(bsr_tgt[k]));
      check_eq("bsr_rs_err", 32'(rs_err), (k == 4) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 5; k++) begin
      exec(8'h40, 8'h00);
      check_eq("rts_pc", 32'(pc), 32'(ret_exp[k]));
    end
    check_eq("rts_rs_err", 32'(rs_err), 32'h1);

    // LMSK then an interrupt raised mid-handshake
    exec(8'h70, 8'h06);
    check_eq("lmsk_pc", 32'(pc), 32'h43);
`ifdef FETCH_CTRL_IRQ_EN
    check_eq("lmsk_mask", 32'(itr_mask), 32'h6);
`else
    check_eq("lmsk_mask", 32'(itr_mask), 32'h0);
`endif
    instr = 8'h00; stg1_ready = 1'b0;
    step();
    step();
`ifdef FETCH_CTRL_IRQ_EN
    irq = 4'b1110;
`else
    irq = 4'hF;
`endif
    step();
    check_eq("irq_no_abort", 32'(state), 32'(StIssue));
    stg1_ready = 1'b1;
    step();
`ifdef FETCH_CTRL_IRQ_EN
    check_eq("irq_save", 32'(state), 32'(StIrqSave));
    check_eq("irq_save_pc", 32'(pc), 32'h44);
    step();
    check_eq("irq_vec", 32'(state), 32'(StIrqVec));
    check_eq("irq_in_isr", 32'(in_isr), 32'h1);
    step();
    check_eq("irq_vec_state", 32'(state), 32'(StFetch));
    check_eq("irq_vec_pc", 32'(pc), 32'hF1);
    irq = 4'h0;
    exec(8'h48, 8'h00);
    check_eq("rti_pc", 32'(pc), 32'h44);
    check_eq("rti_in_isr", 32'(in_isr), 32'h0);
`else
    check_eq("noirq_state", 32'(state), 32'(StFetch));
    check_eq("noirq_pc", 32'(pc), 32'h44);
    check_eq("noirq_in_isr", 32'(in_isr), 32'h0);
    exec(8'hA8, 8'h20);
    check_eq("noirq_bsr_pc", 32'(pc), 32'h20);
    exec(8'h48, 8'h00);
    check_eq("noirq_rti_pc", 32'(pc), 32'h45);
    check_eq("noirq_mask", 32'(itr_mask), 32'h0);
    irq = 4'h0;
`endif

    // Reset in the middle of a handshake
    instr = 8'h00; stg1_ready = 1'b0;
    step();
    step();
    check_eq("mid_rst_valid_before", 32'(stg0_valid), 32'h1);
    clr = 1'b0;
    step();
    check_eq("mid_rst_valid", 32'(stg0_valid), 32'h0);
    check_eq("mid_rst_pc", 32'(pc), 32'h0);
    check_eq("mid_rst_state", 32'(state), 32'(StFetch));
    check_eq("mid_rst_rs_err", 32'(rs_err), 32'h0);
    check_eq("mid_rst_fetch_en", 32'(fetch_en), 32'h0);
    check_eq("mid_rst_in_isr", 32'(in_isr), 32'h0);
    clr = 1'b1;
    #1;
    check_eq("mid_rst_release_fetch", 32'(fetch_en), 32'h1);
    step();
    check_eq("mid_rst_pc_after", 32'(pc), 32'h1);

`ifdef FETCH_CTRL_IRQ_EN
    check_eq("saw_irq", 32'(saw_irq), 32'h1);
`else
    check_eq("saw_irq", 32'(saw_irq), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameters:
  - PC_W, default 8: PC and operand width.
  - NIRQ, default 4: number of interrupt lines and mask width.
  - BR_WAIT, default 2: number of flag-settle cycles before a branch resolves, minimum 1.
  - RS_DEPTH, default 4: return-stack entries, minimum 2.
  - VEC_BASE, default 8'hF0: first interrupt vector address.
REQ-002 SHALL have ports, in this order:
  - clk  in  1: the single clock.
  - clr  in  1: reset, synchronous and active-low.
  - instr  in  8: opcode in [7:3], condition in [2:0].
  - operand  in  PC_W: branch/jump target, or mask value for LMSK.
  - irq  in  NIRQ: pending interrupt lines.
  - ccr_z  in  1: zero flag.
  - ccr_c  in  1: carry flag.
  - stg1_ready  in  1: stage-1 accept/done.
  - stg0_valid  out  1: instruction handed to stage 1.
  - fetch_en  out  1: memory read strobe.
  - pc  out  PC_W: program counter.
  - itr_mask  out  NIRQ: interrupt enable mask, 1 = enabled.
  - in_isr  out  1: interrupt being serviced.
  - rs_err  out  1: sticky return-stack overflow/underflow flag.
  - state  out  4: encoded FSM state, for debug.

Function
REQ-003 SHALL implement these FSM states: FETCH, DECODE, ISSUE, BRWAIT, JUMP, CALL, RET, LMSK, IRQ_SAVE, IRQ_VEC.
REQ-004 FETCH SHALL assert fetch_en for exactly one cycle, set pc <= pc+1 (wrapping modulo 2^PC_W), then go to DECODE.
REQ-005 DECODE SHALL dispatch on the opcode:
  - BRA 00110 -> ISSUE, then BRWAIT.
  - JMP 00111 -> JUMP.
  - BSR 10101 -> CALL.
  - RTS 01000 and RTI 01001 -> RET.
  - LMSK 01110 -> LMSK.
  - any other opcode -> ISSUE.
REQ-006 ISSUE SHALL hold stg0_valid=1 until stg1_ready=1 is sampled, then leave on the following edge; stg0_valid SHALL be 0 in every other state.
REQ-007 BRWAIT SHALL last exactly BR_WAIT cycles and evaluate the condition in its last cycle:
  - 000 BEQ: taken when z=1.
  - 001 BNE: taken when z=0.
  - 010 BCS: taken when c=1.
  - 011 BCC: taken when c=0.
  - 111 BAL: always taken.
  - any other code: never taken.
REQ-008 A taken branch and JUMP SHALL load pc <= operand; a not-taken branch SHALL leave pc unchanged; both SHALL continue to the boundary check.
REQ-009 CALL SHALL push pc and load pc <= operand in one cycle; a push onto a full stack SHALL be dropped and set rs_err, and the jump is still taken.
REQ-010 RET SHALL pop into pc in one cycle; a pop from an empty stack SHALL leave pc unchanged and set rs_err; RTI SHALL additionally clear in_isr.
REQ-011 LMSK SHALL load itr_mask <= operand[NIRQ-1:0].
REQ-012 The boundary check (the exit of ISSUE-non-branch, BRWAIT, JUMP, CALL, RET, LMSK) SHALL go to IRQ_SAVE when |(irq & itr_mask) and in_isr=0; otherwise it SHALL go to FETCH.
REQ-013 IRQ_SAVE SHALL push pc (overflow per REQ-009) and set in_isr=1; IRQ_VEC SHALL load pc <= VEC_BASE + index of the lowest set bit of irq & itr_mask, then go to FETCH.
REQ-014 irq SHALL be sampled only at the boundary check; an interrupt asserted mid-instruction or mid-handshake SHALL NOT abort that instruction.
REQ-015 rs_err SHALL stay set until reset; simultaneous push and pop SHALL NOT occur by construction.

Reset
REQ-016 With clr=0 at a clock edge:
  - state SHALL become FETCH.
  - pc, itr_mask, in_isr, rs_err, stg0_valid, fetch_en and the stack pointer SHALL become 0.
  - stg0_valid SHALL drop on that edge even in mid-handshake.
REQ-017 The first fetch SHALL occur in the cycle after clr returns to 1.

Configuration
REQ-018 With macro FETCH_CTRL_IRQ_EN defined, interrupt entry per REQ-012 to REQ-014 SHALL be present.
REQ-019 Without FETCH_CTRL_IRQ_EN:
  - irq SHALL be ignored, and itr_mask and in_isr SHALL be tied to 0.
  - LMSK SHALL act as a no-op to the boundary check.
  - RTI SHALL behave as RTS.
  - IRQ_SAVE and IRQ_VEC SHALL be unreachable.

Structure
REQ-020 A shared package fetch_pkg SHALL hold the opcode constants, the condition-code constants and the state encoding.
REQ-021 The return stack SHALL be the sub-module fetch_rstack (a RS_DEPTH x PC_W LIFO with push, pop, full and empty).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Reset, then NOP 00000xxx with stg1_ready held low 3 cycles -> stg0_valid high 3 cycles; pc=1; next FETCH after ready.
  - BEQ with operand=8'h40, z=1 at the last BRWAIT cycle, BR_WAIT=2 -> pc=8'h40; with z=0 -> pc=2.
  - Five BSRs with RS_DEPTH=4, then five RTS -> rs_err=1 after the fifth BSR; four correct returns; the fifth RTS leaves pc unchanged.
  - LMSK operand=4'b0110, irq=4'b1110 during ISSUE -> no entry before the boundary; then pc=VEC_BASE+1, in_isr=1; RTI restores pc and clears in_isr.
  - clr=0 asserted during ISSUE -> stg0_valid=0 and pc=0 on the next edge; fetch_en=1 in the cycle after clr releases.
  - Build without FETCH_CTRL_IRQ_EN, irq=4'hF -> never vectors; itr_mask=0.
